// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target: FSM state encoding (mirrors
// state_out) and the bus-level ACK/NACK bit values.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_RX        = 4'd3,
        ST_RX_ACK    = 4'd4,
        ST_TX        = 4'd5,
        ST_TX_ACK    = 4'd6,
        ST_WAIT_STOP = 4'd7
    } i2c_sub_state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    function automatic logic is_busy_state(input i2c_sub_state_t st);
        return (st != ST_IDLE) && (st != ST_WAIT_STOP);
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizer with registered SCL edge strobes and START/STOP detection.
// Strobes appear SYNC_STAGES+1 clk cycles after a pin change.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);
    import i2c_pkg::*;

    logic [SYNC_STAGES-1:0] scl_sync_r;
    logic [SYNC_STAGES-1:0] sda_sync_r;
    logic                   scl_hist_r;
    logic                   sda_hist_r;
    logic                   scl_now_s;
    logic                   sda_now_s;
    logic                   scl_rise_r;
    logic                   scl_fall_r;
    logic                   start_det_r;
    logic                   stop_det_r;
    logic                   sda_s_r;

    assign scl_now_s = scl_sync_r[SYNC_STAGES-1];
    assign sda_now_s = sda_sync_r[SYNC_STAGES-1];

    // Free-running synchronizer and history flops: they keep tracking the pins
    // through reset so a held-low SDA cannot fake a START when reset drops.
    always_ff @(posedge clk) begin
        scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl_in};
        sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda_in};
        scl_hist_r <= scl_now_s;
        sda_hist_r <= sda_now_s;
    end

    // Registered strobes; START/STOP need SCL high in both samples, so a
    // simultaneous SCL/SDA move counts as a data edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_rise_r  <= 1'b0;
            scl_fall_r  <= 1'b0;
            start_det_r <= 1'b0;
            stop_det_r  <= 1'b0;
            sda_s_r     <= 1'b1;
        end else begin
            scl_rise_r  <= scl_now_s & ~scl_hist_r;
            scl_fall_r  <= ~scl_now_s & scl_hist_r;
            start_det_r <= scl_now_s & scl_hist_r & sda_hist_r & ~sda_now_s;
            stop_det_r  <= scl_now_s & scl_hist_r & ~sda_hist_r & sda_now_s;
            sda_s_r     <= sda_now_s;
        end
    end

    assign scl_rise  = scl_rise_r;
    assign scl_fall  = scl_fall_r;
    assign start_det = start_det_r;
    assign stop_det  = stop_det_r;
    assign sda_s     = sda_s_r;

endmodule

// File: rtl/i2c_subordinate.sv
// Single-address I2C target: address match with ACK, unbounded multibyte
// writes into rx_data, and reads that stream tx_data MSB first.
module i2c_subordinate #(
    parameter logic [6:0] ADDR        = 7'h01,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       addr_hit,
    output logic       busy,
    output logic [3:0] state_out
);
    import i2c_pkg::*;

    logic scl_rise_s, scl_fall_s, start_det_s, stop_det_s, sda_s;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl_rise  (scl_rise_s),
        .scl_fall  (scl_fall_s),
        .start_det (start_det_s),
        .stop_det  (stop_det_s),
        .sda_s     (sda_s)
    );

    i2c_sub_state_t state_r, state_nx_s;
    logic [3:0] bit_cnt_r, cnt_nx_s;
    logic [7:0] shift_r, shift_nx_s, rx_data_r, rx_data_nx_s, byte_in_s;
    logic       rw_r, rw_nx_s, phase_r, phase_nx_s, sda_oe_r, sda_oe_nx_s;
    logic       rx_valid_r, rx_valid_nx_s, addr_hit_r, addr_hit_nx_s, busy_r;
    logic [2:0] tx_idx_s;

    assign byte_in_s = {shift_r[6:0], sda_s};
    // After k bits have been clocked out, the next bit to present is 7-k.
    assign tx_idx_s  = 3'(4'd7 - bit_cnt_r);

    // Next-state and datapath decisions; phase_r marks the second half of an ACK slot.
    always_comb begin
        state_nx_s    = state_r;
        cnt_nx_s      = bit_cnt_r;
        shift_nx_s    = shift_r;
        rw_nx_s       = rw_r;
        phase_nx_s    = phase_r;
        sda_oe_nx_s   = sda_oe_r;
        rx_data_nx_s  = rx_data_r;
        rx_valid_nx_s = 1'b0;
        addr_hit_nx_s = 1'b0;
        if (stop_det_s) begin
            state_nx_s  = ST_IDLE;
            sda_oe_nx_s = 1'b0;
        end else if (start_det_s) begin
            state_nx_s  = ST_ADDR;
            cnt_nx_s    = 4'd0;
            sda_oe_nx_s = 1'b0;
            phase_nx_s  = 1'b0;
        end else begin
            case (state_r)
                ST_ADDR, ST_RX: begin
                    if (scl_rise_s) begin
                        shift_nx_s = byte_in_s;
                        cnt_nx_s   = bit_cnt_r + 4'd1;
                        phase_nx_s = 1'b0;
                        if (bit_cnt_r != 4'd7) begin
                            state_nx_s = state_r;
                        end else if (state_r == ST_RX) begin
                            state_nx_s    = ST_RX_ACK;
                            rx_data_nx_s  = byte_in_s;
                            rx_valid_nx_s = 1'b1;
                        end else if (byte_in_s[7:1] == ADDR) begin
                            state_nx_s    = ST_ADDR_ACK;
                            addr_hit_nx_s = 1'b1;
                            rw_nx_s       = byte_in_s[0];
                        end else begin
                            state_nx_s = ST_WAIT_STOP;
                        end
                    end else begin
                        state_nx_s = state_r;
                    end
                end
                ST_ADDR_ACK, ST_RX_ACK: begin
                    if (scl_fall_s && !phase_r) begin
                        sda_oe_nx_s = 1'b1;
                        phase_nx_s  = 1'b1;
                    end else if (scl_fall_s) begin
                        phase_nx_s = 1'b0;
                        cnt_nx_s   = 4'd0;
                        if ((state_r == ST_ADDR_ACK) && rw_r) begin
                            state_nx_s  = ST_TX;
                            shift_nx_s  = tx_data;
                            sda_oe_nx_s = ~tx_data[7];
                        end else begin
                            state_nx_s  = ST_RX;
                            sda_oe_nx_s = 1'b0;
                        end
                    end else begin
                        phase_nx_s = phase_r;
                    end
                end
                ST_TX: begin
                    if (scl_rise_s) begin
                        cnt_nx_s = bit_cnt_r + 4'd1;
                    end else if (scl_fall_s && (bit_cnt_r == 4'd8)) begin
                        state_nx_s  = ST_TX_ACK;
                        sda_oe_nx_s = 1'b0;
                        phase_nx_s  = 1'b0;
                    end else if (scl_fall_s) begin
                        sda_oe_nx_s = ~shift_r[tx_idx_s];
                    end else begin
                        cnt_nx_s = bit_cnt_r;
                    end
                end
                ST_TX_ACK: begin
                    if (scl_rise_s && (sda_s == I2C_ACK)) begin
                        phase_nx_s = 1'b1;
                    end else if (scl_rise_s) begin
                        state_nx_s = ST_WAIT_STOP;
                    end else if (scl_fall_s && phase_r) begin
                        state_nx_s  = ST_TX;
                        shift_nx_s  = tx_data;
                        sda_oe_nx_s = ~tx_data[7];
                        cnt_nx_s    = 4'd0;
                        phase_nx_s  = 1'b0;
                    end else begin
                        phase_nx_s = phase_r;
                    end
                end
                ST_IDLE, ST_WAIT_STOP: begin
                    sda_oe_nx_s = 1'b0;
                end
                default: begin
                    state_nx_s  = ST_IDLE;
                    sda_oe_nx_s = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= 4'd0;
            shift_r    <= 8'h00;
            rw_r       <= 1'b0;
            phase_r    <= 1'b0;
            sda_oe_r   <= 1'b0;
            rx_data_r  <= 8'h00;
            rx_valid_r <= 1'b0;
            addr_hit_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            bit_cnt_r  <= cnt_nx_s;
            shift_r    <= shift_nx_s;
            rw_r       <= rw_nx_s;
            phase_r    <= phase_nx_s;
            sda_oe_r   <= sda_oe_nx_s;
            rx_data_r  <= rx_data_nx_s;
            rx_valid_r <= rx_valid_nx_s;
            addr_hit_r <= addr_hit_nx_s;
            busy_r     <= is_busy_state(state_nx_s);
        end
    end

    assign sda_oe    = sda_oe_r;
    assign rx_data   = rx_data_r;
    assign rx_valid  = rx_valid_r;
    assign addr_hit  = addr_hit_r;
    assign busy      = busy_r;
    assign state_out = state_r;

endmodule

// File: tb/tb_i2c_subordinate.sv
// Bit-banged I2C master driving the target over an open-drain SDA; expected
// rx bytes and address hits are queued per transaction and popped by monitors.
module tb_i2c_subordinate;

    localparam logic [6:0] DUT_ADDR = 7'h01;
    localparam int         Q        = 8;
    localparam logic       ACK_BIT  = 1'b0;
    localparam logic       NACK_BIT = 1'b1;

    logic       clk = 1'b0;
    logic       rst, scl_drv, sda_drv, sda_line;
    logic       sda_oe, rx_valid, addr_hit, busy;
    logic [7:0] tx_data, rx_data;
    logic [3:0] state_out;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         frame_id = 0;
    logic [7:0] exp_rx_q[$];
    int         exp_hit_q[$];
    logic [7:0] wr_bytes[$];
    logic       oe_prev  = 1'b0;
    logic       oe_seen  = 1'b0;
    logic       oe_hi_ok = 1'b0;

    assign sda_line = sda_drv & ~sda_oe;

    always #5 clk = ~clk;

    i2c_subordinate #(.ADDR(DUT_ADDR), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (scl_drv),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .tx_data   (tx_data),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .addr_hit  (addr_hit),
        .busy      (busy),
        .state_out (state_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // rx monitor: every rx_valid pulse must match the oldest expected byte
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            check("rx_valid_expected", 32'(exp_rx_q.size() != 0), 32'd1);
            if (exp_rx_q.size() != 0) check("rx_data", rx_data, exp_rx_q.pop_front());
        end
    end

    // address monitor: every addr_hit must belong to the frame currently on the bus
    always @(negedge clk) begin
        if (addr_hit === 1'b1) begin
            check("addr_hit_expected", 32'(exp_hit_q.size() != 0), 32'd1);
            if (exp_hit_q.size() != 0) check("addr_hit_frame", exp_hit_q.pop_front(), frame_id);
        end
    end

    // SDA drive monitor: target may only move SDA while SCL is low
    always @(negedge clk) begin
        if (sda_oe === 1'b1) oe_seen = 1'b1;
        if (sda_oe !== oe_prev) begin
            if (!oe_hi_ok) check("oe_change_scl_low", scl_drv, 1'b0);
            oe_prev = sda_oe;
        end
    end

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clock_bit(input logic b, output logic s);
        sda_drv = b;    tick(Q);
        scl_drv = 1'b1; tick(Q);
        s = sda_line;   tick(Q);
        scl_drv = 1'b0; tick(Q);
    endtask

    task automatic bus_start();
        sda_drv = 1'b1; tick(Q);
        scl_drv = 1'b1; tick(Q);
        frame_id++;
        oe_seen = 1'b0;
        sda_drv = 1'b0; tick(Q);
        check("start_state", state_out, 4'd1);
        scl_drv = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        sda_drv = 1'b0; tick(Q);
        scl_drv = 1'b1; tick(Q);
        sda_drv = 1'b1; tick(2 * Q);
        check("stop_state", state_out, 4'd0);
        check("stop_busy", busy, 1'b0);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
        clock_bit(1'b1, ack);
    endtask

    // Model: matching address is ACKed and every written byte is ACKed and
    // delivered; any other address is never driven and its data never delivered.
    task automatic write_xfer(input logic [6:0] a, input logic do_stop);
        logic ack, hit;
        hit = (a == DUT_ADDR);
        bus_start();
        if (hit) exp_hit_q.push_back(frame_id);
        write_byte({a, 1'b0}, ack);
        check("addr_ack", ack, hit ? ACK_BIT : NACK_BIT);
        check("busy_after_addr", busy, hit);
        if (hit) begin
            foreach (wr_bytes[k]) begin
                exp_rx_q.push_back(wr_bytes[k]);
                write_byte(wr_bytes[k], ack);
                check("data_ack", ack, ACK_BIT);
            end
        end else begin
            write_byte(8'($urandom), ack);
            check("ignored_data_ack", ack, NACK_BIT);
            check("no_drive_frame", oe_seen, 1'b0);
        end
        if (do_stop) bus_stop();
    endtask

    // Model: each byte read equals tx_data as presented before that byte's load.
    task automatic read_xfer(input logic [6:0] a, input int n, input logic [7:0] first);
        logic       ack, hit, s;
        logic [7:0] cur, got;
        hit = (a == DUT_ADDR);
        cur = first;
        tx_data = cur;
        bus_start();
        if (hit) exp_hit_q.push_back(frame_id);
        write_byte({a, 1'b1}, ack);
        check("addr_ack_rd", ack, hit ? ACK_BIT : NACK_BIT);
        if (hit) begin
            for (int k = 0; k < n; k++) begin
                for (int i = 7; i >= 0; i--) begin
                    clock_bit(1'b1, s);
                    got[i] = s;
                end
                check("read_data", got, cur);
                if (k < n - 1) begin
                    cur = 8'($urandom);
                    tx_data = cur;
                    clock_bit(ACK_BIT, s);
                end else begin
                    clock_bit(NACK_BIT, s);
                    tick(2);
                    check("nack_wait_stop", state_out, 4'd7);
                    check("nack_busy", busy, 1'b0);
                end
            end
        end else begin
            check("no_drive_rd", oe_seen, 1'b0);
        end
        bus_stop();
    endtask

    initial begin
        logic ack, s;
        rst = 1'b1; scl_drv = 1'b1; sda_drv = 1'b1; tx_data = 8'h00;
        tick(6);
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_addr_hit", addr_hit, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_state", state_out, 4'd0);
        rst = 1'b0;
        tick(4);

        wr_bytes.delete(); wr_bytes.push_back(8'hAB);
        write_xfer(7'h01, 1'b1);
        wr_bytes.delete(); wr_bytes.push_back(8'h5A);
        write_xfer(7'h22, 1'b1);
        read_xfer(7'h01, 1, 8'hC3);
        wr_bytes.delete(); wr_bytes.push_back(8'h12); wr_bytes.push_back(8'h34);
        write_xfer(7'h01, 1'b1);
        wr_bytes.delete(); wr_bytes.push_back(8'h77);
        write_xfer(7'h01, 1'b0);
        read_xfer(7'h01, 2, 8'h96);

        // reset while the target is driving a 0 in the middle of a read byte
        bus_start();
        exp_hit_q.push_back(frame_id);
        tx_data = 8'h00;
        write_byte({DUT_ADDR, 1'b1}, ack);
        check("addr_ack_rst", ack, ACK_BIT);
        for (int i = 0; i < 3; i++) clock_bit(1'b1, s);
        sda_drv = 1'b1; tick(Q);
        scl_drv = 1'b1; tick(Q / 2);
        check("tx_drive_before_rst", sda_oe, 1'b1);
        oe_hi_ok = 1'b1;
        rst = 1'b1; tick(1);
        check("rst_mid_oe", sda_oe, 1'b0);
        check("rst_mid_state", state_out, 4'd0);
        rst = 1'b0; tick(Q / 2);
        scl_drv = 1'b0; tick(Q);
        oe_hi_ok = 1'b0;
        oe_seen = 1'b0;
        write_byte({DUT_ADDR, 1'b0}, ack);
        check("post_rst_ignored", ack, NACK_BIT);
        check("post_rst_no_drive", oe_seen, 1'b0);
        check("post_rst_state", state_out, 4'd0);
        bus_stop();

        for (int t = 0; t < 10; t++) begin
            logic [6:0] a;
            int         n;
            a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : DUT_ADDR;
            n = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 0) begin
                wr_bytes.delete();
                for (int k = 0; k < n; k++) wr_bytes.push_back(8'($urandom));
                write_xfer(a, 1'b1);
            end else begin
                read_xfer(a, n, 8'($urandom));
            end
        end

        tick(10);
        check("rx_queue_drained", exp_rx_q.size(), 32'd0);
        check("hit_queue_drained", exp_hit_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_subordinate.md
# i2c_subordinate

Single-address I2C target that sits on the bus directly downstream of `I2C_master` and consumes its SCL/SDA traffic. It oversamples both lines in the system clock domain, detects START/STOP, matches a fixed 7-bit address and ACKs it. On writes it shifts bytes into `rx_data`; on reads it shifts `tx_data` out MSB first. It replaces behavioural bus models as the synthesizable peer for master bring-up.

## Interface
- `ADDR`, default 7'h01: 7-bit bus address this target answers to.
- `SYNC_STAGES`, default 2: synchronizer depth on `scl_in`/`sda_in`; minimum 2.
- `clk`  in  1  system clock; at least 16x the SCL frequency.
- `rst`  in  1  reset, synchronous and active-high.
- `scl_in`  in  1  SCL pin state (asynchronous to `clk`).
- `sda_in`  in  1  SDA pin state (asynchronous to `clk`).
- `sda_oe`  out  1  1 = pull SDA low (open-drain); 0 = release the line.
- `tx_data`  in  8  byte returned on reads; sampled when a read address is ACKed and again after each master ACK.
- `rx_data`  out  8  last complete byte written by the master.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates.
- `addr_hit`  out  1  one-cycle pulse when the address byte matches `ADDR`.
- `busy`  out  1  high from an address match until STOP or NACK.
- `state_out`  out  4  current FSM state, for debug.

## Operation
- Line conditioning:
  - Both lines pass through `SYNC_STAGES` flops, then one history flop for edge detection.
  - SCL rise/fall are one-cycle strobes.
  - START is SDA falling while synchronized SCL is high; STOP is SDA rising while SCL is high.
- FSM states: IDLE(0), ADDR(1), ADDR_ACK(2), RX(3), RX_ACK(4), TX(5), TX_ACK(6), WAIT_STOP(7).
- START in any state: go to ADDR, clear the bit counter, release SDA. This covers repeated START.
- STOP in any state: go to IDLE, release SDA, clear `busy`.
- ADDR:
  - Shift in `sda` on each SCL rise, MSB first; 8 bits total, R/W is the LSB.
  - After the 8th rise: on match, take the ADDR_ACK path and pulse `addr_hit`; on mismatch, go to WAIT_STOP and never drive SDA.
- ADDR_ACK:
  - On SCL fall, set `sda_oe`=1. On the next fall, release it.
  - Then go to RX if R/W=0. If R/W=1, go to TX, load `tx_data` into the shift register, and drive its MSB.
- RX:
  - 8 SCL rises shift bits in.
  - On the 8th rise, latch `rx_data` and pulse `rx_valid`.
  - On the following fall, drive the ACK (RX_ACK). After the ACK clock's fall, return to RX.
  - Multibyte writes are unbounded.
- TX:
  - On each SCL fall, `sda_oe` = ~current bit (a 1 bit releases the line).
  - After 8 bits, release SDA and go to TX_ACK.
- TX_ACK:
  - Sample `sda` on SCL rise.
  - 0 (master ACK): reload `tx_data` and continue in TX.
  - 1 (NACK): go to WAIT_STOP.
- `busy` = state not in {IDLE, WAIT_STOP}.

## Timing
- Reset values: `sda_oe`=0, `rx_data`=8'h00, `rx_valid`=0, `addr_hit`=0, `busy`=0, `state_out`=0.
- Pin-to-strobe latency: `SYNC_STAGES`+1 `clk` cycles.
- `sda_oe` changes only in the cycle after an SCL-fall strobe, or on START/STOP/reset. It is never changed while SCL is high, apart from a STOP-forced release.
- `rx_valid` and `addr_hit` fire in the cycle after the 8th SCL-rise strobe.
- Reset asserted mid-transfer: `sda_oe`=0 on the next edge. Bus activity is then ignored until the next START.
- START and STOP detected in the same cycle is impossible by construction. If SCL and SDA move in the same sample, treat it as a data edge, not START/STOP.

## Structure
- `i2c_pkg` holds:
  - the `i2c_sub_state_t` enum, with encodings matching `state_out`;
  - the `I2C_ACK` (1'b0) and `I2C_NACK` (1'b1) constants.
- Sub-module `i2c_line_sync`: parameterized synchronizer plus edge, START and STOP detector. Its outputs are `scl_rise`, `scl_fall`, `start_det`, `stop_det`, and `sda_s`.

## Test plan
- Master writes 0xAB to 0x01 → ACK in the 9th clock, `addr_hit` pulses once, `rx_data`=0xAB with a single `rx_valid` pulse, `busy` falls after STOP.
- Address 0x22 → `sda_oe` stays 0 for the whole frame, master reports `ack_error`, no `rx_valid`.
- Read from 0x01 with `tx_data`=0xC3 → SDA carries 1,1,0,0,0,0,1,1. Master `data_out`=0xC3; master NACK leads to WAIT_STOP, then IDLE on STOP.
- Write 0x12 then 0x34 in one frame → two `rx_valid` pulses with values 0x12 then 0x34, each ACKed.
- Repeated START after the first data byte, then a read → FSM re-enters ADDR (`state_out`=1) and the read returns `tx_data`.
- `rst` pulsed during TX bit 3 → `sda_oe`=0 on the next cycle, `state_out`=0, and the target ignores traffic until a fresh START.
